// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass and a pending-write scoreboard.
// Reads are combinational (zero latency); writes/issues land on the rising edge; no backpressure.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [ADDR_W:0]            pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_clr;
  logic [DEPTH-1:0]  pend_set;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   dec_cnt;
  logic              inc;
  logic              wa_we;
  logic              wb_we;
  logic              iss_we;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wa_we  = wa_en  && !(ZR && (wa_addr  == '0));
  assign wb_we  = wb_en  && !(ZR && (wb_addr  == '0));
  assign iss_we = iss_en && !(ZR && (iss_addr == '0));

  always_comb begin
    pend_clr = '0;
    pend_set = '0;
    dec_cnt  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pend_clr[k] = (wa_we && (wa_addr == ADDR_W'(k))) || (wb_we && (wb_addr == ADDR_W'(k)));
      pend_set[k] = iss_we && (iss_addr == ADDR_W'(k));
    end
    // A same-cycle set overrides the clear, so only unset pending bits count as released.
    for (int k = 0; k < DEPTH; k++) begin
      dec_cnt = dec_cnt + {{ADDR_W{1'b0}}, pend_clr[k] & pend[k] & ~pend_set[k]};
    end
    inc       = |(pend_set & ~pend);
    pend_next = (pend & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wa_we) regs[wa_addr] <= wa_data;
      if (wb_we) regs[wb_addr] <= wb_data;
      pend     <= pend_next;
      pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, inc} - dec_cnt;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[i*ADDR_W +: ADDR_W];
      if (!reset && rd_en[i]) begin
        if (ZR && (a == '0))
          rd_data[i*DATA_W +: DATA_W] = '0;
        else if (wb_en && (wb_addr == a))
          rd_data[i*DATA_W +: DATA_W] = wb_data;
        else if (wa_en && (wa_addr == a))
          rd_data[i*DATA_W +: DATA_W] = wa_data;
        else
          rd_data[i*DATA_W +: DATA_W] = regs[a];
        rd_busy[i] = pend[a] && !(wa_en && (wa_addr == a)) && !(wb_en && (wb_addr == a));
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass, port priority, zero register and scoreboard counting.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wa_en, wb_en, iss_en;
  logic [4:0]  wa_addr, wb_addr, iss_addr;
  logic [31:0] wa_data, wb_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs then change well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wa_addr = '0; wb_addr = '0; iss_addr = '0;
    wa_data = '0; wb_data = '0;
    rd_en = 2'b11; rd_addr = '0;

    // Reset, with writes/issues present that must be discarded
    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'hABCD;
    iss_en = 1'b1; iss_addr = 5'd6;
    #1 chk("rd_data_gated_in_reset", rd_data, 64'h0);
    chk("rd_busy_gated_in_reset", {62'h0, rd_busy}, 64'h0);
    tick(); tick();
    idle();
    reset = 1'b0;
    #1 chk("pend_cnt_after_reset", {58'h0, pend_cnt}, 64'd0);

    // Test 1: all addresses read zero on both ports
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("reset_rd0", {32'h0, rd_data[31:0]}, 64'h0);
      chk("reset_rd1", {32'h0, rd_data[63:32]}, 64'h0);
    end

    // Test 2: write bypass then stored value
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    rd_addr = {5'd5, 5'd5};
    #1 chk("bypass_wa_addr5", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    tick(); idle();
    chk("stored_addr5", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("stored_addr5_p1", {32'h0, rd_data[63:32]}, 64'hDEADBEEF);

    // Test 3: both ports to addr 7, B wins
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222;
    rd_addr = {5'd5, 5'd7};
    #1 chk("bypass_b_wins", {32'h0, rd_data[31:0]}, 64'h2222);
    tick(); idle();
    chk("stored_b_wins", {32'h0, rd_data[31:0]}, 64'h2222);

    // Test 3b: A bypasses when B targets another address; no pending change
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h3333;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h4444;
    rd_addr = {5'd8, 5'd7};
    #1 chk("bypass_wa_only", {32'h0, rd_data[31:0]}, 64'h3333);
    chk("bypass_wb_p1", {32'h0, rd_data[63:32]}, 64'h4444);
    tick(); idle();
    chk("write_nonpending_cnt", {58'h0, pend_cnt}, 64'd0);

    // Test 4: register 0 hardwired
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    rd_addr = {5'd0, 5'd0};
    #1 chk("zero_reg_bypass", {32'h0, rd_data[31:0]}, 64'h0);
    tick(); idle();
    chk("zero_reg_stored", rd_data, 64'h0);
    iss_en = 1'b1; iss_addr = 5'd0;
    tick(); idle();
    chk("zero_reg_iss_cnt", {58'h0, pend_cnt}, 64'd0);
    chk("zero_reg_busy", {62'h0, rd_busy}, 64'h0);

    // Test 5: issue 9, busy until write-back
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle();
    chk("iss9_cnt", {58'h0, pend_cnt}, 64'd1);
    rd_en = 2'b01; rd_addr = {5'd9, 5'd9};
    #1 chk("iss9_busy", {62'h0, rd_busy}, 64'h1);
    chk("disabled_port_data", {32'h0, rd_data[63:32]}, 64'h0);
    tick();
    chk("iss9_repeat_iss_cnt", {58'h0, pend_cnt}, 64'd1);
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle();
    chk("iss9_reissue_cnt", {58'h0, pend_cnt}, 64'd1);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1 chk("wb9_busy_cleared", {62'h0, rd_busy}, 64'h0);
    chk("wb9_bypass", {32'h0, rd_data[31:0]}, 64'h99);
    tick(); idle();
    chk("wb9_cnt", {58'h0, pend_cnt}, 64'd0);
    rd_en = 2'b11;

    // Test 6: concurrent clears with a same-address re-issue
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    chk("iss3_cnt", {58'h0, pend_cnt}, 64'd1);
    iss_addr = 5'd4;
    tick(); idle();
    chk("iss4_cnt", {58'h0, pend_cnt}, 64'd2);
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hA3;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hB4;
    iss_en = 1'b1; iss_addr = 5'd3;
    tick(); idle();
    chk("clr2_set1_cnt", {58'h0, pend_cnt}, 64'd1);
    rd_addr = {5'd4, 5'd3};
    #1 chk("pend3_busy", {62'h0, rd_busy}, 64'h1);
    chk("stored3", {32'h0, rd_data[31:0]}, 64'hA3);
    chk("stored4", {32'h0, rd_data[63:32]}, 64'hB4);

    // Reset mid-operation discards same-cycle updates
    reset = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234;
    iss_en = 1'b1; iss_addr = 5'd5;
    tick(); idle();
    reset = 1'b0;
    chk("reset_mid_cnt", {58'h0, pend_cnt}, 64'd0);
    rd_addr = {5'd5, 5'd3};
    #1 chk("reset_mid_busy", {62'h0, rd_busy}, 64'h0);
    chk("reset_mid_rd3", {32'h0, rd_data[31:0]}, 64'h0);
    chk("reset_mid_rd5", {32'h0, rd_data[63:32]}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
